mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Iterative unsigned multiply/divide unit in the execute stage.
- Consumes the two operands read out of the register file and returns a single write-back request (address and data) that goes back into the register-file write port.
- Computes one result bit per cycle over DATA_WIDTH cycles.
- Holds the result until the write-back arbiter accepts it.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be >= 2.
- ADDR_WIDTH, 5, register-file address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; discard the operation in progress.
- in_valid  in  1  operand request valid.
- in_ready  out  1  unit can accept a request.
- in_op  in  2  operation: 00 MUL (low half), 01 MULHU (high half), 10 DIVU, 11 REMU.
- in_src1  in  DATA_WIDTH  operand A (multiplicand or dividend).
- in_src2  in  DATA_WIDTH  operand B (multiplier or divisor).
- in_rd  in  ADDR_WIDTH  destination register.
- wb_valid  out  1  result valid.
- wb_ready  in  1  result consumed.
- wb_waddr  out  ADDR_WIDTH  destination register for the result.
- wb_wdata  out  DATA_WIDTH  result data.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low on rst_n; it is asserted immediately and released synchronously.
- Reset state:
  - state=IDLE, counter=0, in_ready=1, wb_valid=0.
  - wb_waddr=0, wb_wdata=0, all internal operand/accumulator registers=0.
- States:
  - IDLE: in_ready=1, wb_valid=0.
  - BUSY: in_ready=0, wb_valid=0.
  - DONE: in_ready=0, wb_valid=1.
- IDLE -> BUSY:
  - Taken on an edge with in_valid&&in_ready&&!flush.
  - At that edge: latch in_op, in_src1, in_src2, in_rd; clear the accumulator/remainder; set counter=0.
- BUSY:
  - Each edge performs one iteration and increments counter.
  - On the edge where counter==DATA_WIDTH-1, move to DONE and load wb_wdata/wb_waddr.
  - BUSY therefore lasts exactly DATA_WIDTH cycles; wb_valid is first high after the DATA_WIDTH-th edge following the accepting edge.
- Multiply (shift-add, LSB of multiplier first):
  - Builds a 2*DATA_WIDTH product.
  - MUL returns bits [DATA_WIDTH-1:0]; MULHU returns bits [2*DATA_WIDTH-1:DATA_WIDTH].
- Divide (restoring, MSB of dividend first):
  - Width is DATA_WIDTH+1 so the subtract sign is explicit.
  - DIVU returns the quotient; REMU returns the remainder.
- Divide by zero: no special path; the restoring algorithm naturally yields quotient=all ones and remainder=dividend. Latency is unchanged.
- DONE:
  - wb_waddr and wb_wdata stay stable while wb_valid=1.
  - On an edge with wb_ready=1, go to IDLE and drop wb_valid.
  - No new request is accepted in that same cycle (in_ready=0 in DONE).
  - Minimum spacing between accepts is DATA_WIDTH+2 cycles.
- rd=0: computed and presented like any other destination; the register file drops writes to register 0.
- flush:
  - From any state, flush=1 at an edge forces IDLE with wb_valid=0 and counter=0.
  - flush takes priority over accept and over wb handshake.
  - A result in DONE that is flushed is lost, even if wb_ready was also 1.
- Reset mid-operation: immediately returns to the reset state; no wb_valid pulse is produced.
- in_valid while not ready: ignored; the requester must hold it.

Test Plan:
- MUL 7*6, rd=3 -> wb_valid after 32 cycles, wb_waddr=3, wb_wdata=0x0000002A; held until wb_ready=1.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> wb_wdata=0xFFFFFFFE; MUL with the same operands -> 0x00000001.
- DIVU 100/7 -> 14 (0x0E); REMU 100/7 -> 2; DIVU 0x80000000/1 -> 0x80000000.
- DIVU 0x1234/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x00001234; both at latency 32.
- wb_ready held 0 for 10 cycles -> wb_valid, wb_waddr, wb_wdata stable and in_ready=0; in_valid pulsed in that window is not accepted.
- flush at BUSY cycle 15 -> IDLE next cycle, no wb_valid. rst_n dropped in DONE -> wb_valid=0 immediately. A new request after flush returns its own correct result.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply/divide unit: one result bit per cycle, result held
// as a register-file write-back request until the arbiter takes it.
module mdu_iter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_src1,
  input  logic [DATA_WIDTH-1:0] in_src2,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [ADDR_WIDTH-1:0] wb_waddr,
  output logic [DATA_WIDTH-1:0] wb_wdata
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;

  logic [CW-1:0]         cnt;
  logic [1:0]            op;
  logic [ADDR_WIDTH-1:0] rd;
  logic [W-1:0]          opb;   // multiplicand or divisor
  logic [W-1:0]          sh;    // multiplier -> product low / dividend -> quotient
  logic [W-1:0]          acc;   // product high half / remainder
  logic [W-1:0]          acc_nx, sh_nx, res;
  logic [W:0]            sum, shifted, diff;
  logic                  last;

  assign last     = (cnt == CW'(W-1));
  assign in_ready = (state == IDLE);
  assign wb_valid = (state == DONE);

  // One iteration of either algorithm; op[1] selects divide.
  always_comb begin
    sum     = {1'b0, acc} + (sh[0] ? {1'b0, opb} : '0);
    shifted = {acc, sh[W-1]};
    diff    = shifted - {1'b0, opb};
    acc_nx  = acc;
    sh_nx   = sh;
    if (!op[1]) begin
      acc_nx = sum[W:1];
      sh_nx  = {sum[0], sh[W-1:1]};
    end else if (diff[W]) begin
      acc_nx = shifted[W-1:0];
      sh_nx  = {sh[W-2:0], 1'b0};
    end else begin
      acc_nx = diff[W-1:0];
      sh_nx  = {sh[W-2:0], 1'b1};
    end
    case (op)
      2'b00:   res = sh_nx;
      2'b01:   res = acc_nx;
      2'b10:   res = sh_nx;
      default: res = acc_nx;
    endcase
  end

  always_comb begin
    state_nx = state;
    if (flush) state_nx = IDLE;
    else begin
      case (state)
        IDLE:    if (in_valid) state_nx = BUSY;
        BUSY:    if (last)     state_nx = DONE;
        DONE:    if (wb_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op       <= '0;
      rd       <= '0;
      opb      <= '0;
      sh       <= '0;
      acc      <= '0;
      wb_waddr <= '0;
      wb_wdata <= '0;
    end else begin
      state <= state_nx;
      if (flush) cnt <= '0;
      else begin
        case (state)
          IDLE: if (in_valid) begin
            op  <= in_op;
            rd  <= in_rd;
            opb <= in_op[1] ? in_src2 : in_src1;
            sh  <= in_op[1] ? in_src1 : in_src2;
            acc <= '0;
            cnt <= '0;
          end
          BUSY: begin
            acc <= acc_nx;
            sh  <= sh_nx;
            cnt <= cnt + 1'b1;
            if (last) begin
              cnt      <= '0;
              wb_wdata <= res;
              wb_waddr <= rd;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mdu_iter.sv
// Randomized scoreboard bench for mdu_iter against a plain-arithmetic model.
module tb_mdu_iter;
  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk = 0, rst_n = 0, flush = 0, in_valid = 0, wb_ready = 0;
  logic [1:0]    in_op = 0;
  logic [W-1:0]  in_src1 = 0, in_src2 = 0;
  logic [AW-1:0] in_rd = 0;
  logic          in_ready, wb_valid;
  logic [AW-1:0] wb_waddr;
  logic [W-1:0]  wb_wdata;

  int n_chk = 0, n_pass = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [W-1:0]  d;
  } exp_t;
  exp_t sb[$];

  mdu_iter #(.DATA_WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_rd(in_rd),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_waddr(wb_waddr), .wb_wdata(wb_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      2'd0:    return p[W-1:0];
      2'd1:    return p[2*W-1:W];
      2'd2:    return (b == 0) ? {W{1'b1}} : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Monitor: pops on each completed write-back, checks hold stability otherwise.
  initial begin
    exp_t e;
    logic hold_v;
    logic [AW-1:0] pa;
    logic [W-1:0] pd;
    hold_v = 0; pa = 0; pd = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) hold_v = 0;
      else begin
        if (wb_valid && hold_v) begin
          chk("wb_hold_addr", wb_waddr, pa);
          chk("wb_hold_data", wb_wdata, pd);
        end
        if (wb_valid && wb_ready && !flush) begin
          if (sb.size() == 0) chk("unexpected_wb", 1, 0);
          else begin
            e = sb.pop_front();
            chk("wb_addr", wb_waddr, e.a);
            chk("wb_data", wb_wdata, e.d);
          end
        end
        hold_v = wb_valid && !wb_ready && !flush;
        pa = wb_waddr;
        pd = wb_wdata;
      end
    end
  end

  // Presents a request and returns #1 after the accepting edge.
  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [AW-1:0] rd, input bit push);
    exp_t e;
    int t;
    t = 0;
    in_valid = 1; in_op = op; in_src1 = a; in_src2 = b; in_rd = rd;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) begin
        chk("accept_timeout", 0, 1);
        in_valid = 0;
        return;
      end
    end
    @(posedge clk); #1;
    in_valid = 0;
    if (push) begin
      e.a = rd; e.d = model(op, a, b);
      sb.push_back(e);
    end
  endtask

  task automatic wait_wb();
    int lat;
    lat = 0;
    while (!wb_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, W);
  endtask

  task automatic finish_wb(input int hold);
    for (int i = 0; i < hold; i++) begin
      if (i == 2) begin in_valid = 1; in_op = 2'd2; in_src1 = 9; in_src2 = 3; end
      @(posedge clk); #1;
      in_valid = 0;
      chk("in_ready_done", in_ready, 0);
      chk("wb_valid_done", wb_valid, 1);
    end
    wb_ready = 1;
    @(posedge clk); #1;
    wb_ready = 0;
    chk("idle_after_wb", {in_ready, wb_valid}, 2'b10);
  endtask

  task automatic run(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [AW-1:0] rd, input int hold);
    start_op(op, a, b, rd, 1);
    wait_wb();
    finish_wb(hold);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom % 5)
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom % 16);
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    #12;
    chk("reset_ready", in_ready, 1);
    chk("reset_valid", wb_valid, 0);
    chk("reset_addr", wb_waddr, 0);
    chk("reset_data", wb_wdata, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    run(2'd0, 7, 6, 3, 3);
    run(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
    run(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1);
    run(2'd2, 100, 7, 4, 0);
    run(2'd3, 100, 7, 5, 0);
    run(2'd2, 32'h8000_0000, 1, 6, 0);
    run(2'd2, 32'h1234, 0, 7, 0);
    run(2'd3, 32'h1234, 0, 0, 0);
    run(2'd0, 32'hDEAD_BEEF, 32'h1234_5678, 9, 10);

    // flush mid-BUSY: result must vanish
    start_op(2'd0, 5, 5, 10, 0);
    repeat (14) @(posedge clk);
    #1 flush = 1;
    @(posedge clk); #1 flush = 0;
    chk("flush_idle", {in_ready, wb_valid}, 2'b10);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (wb_valid) seen = 1; end
    chk("no_wb_after_flush", seen, 0);
    run(2'd2, 1000, 3, 11, 0);

    // flush in DONE wins over wb_ready
    start_op(2'd1, 32'h8000_0000, 4, 12, 0);
    wait_wb();
    flush = 1; wb_ready = 1;
    @(posedge clk); #1 flush = 0; wb_ready = 0;
    chk("flush_done_idle", {in_ready, wb_valid}, 2'b10);

    // reset in DONE
    start_op(2'd3, 77, 5, 13, 0);
    wait_wb();
    rst_n = 0;
    #1;
    chk("rst_done_valid", wb_valid, 0);
    chk("rst_done_ready", in_ready, 1);
    chk("rst_done_data", {wb_waddr, wb_wdata}, 0);
    #2 rst_n = 1;
    @(posedge clk); #1;
    run(2'd3, 1000, 7, 14, 0);

    for (int i = 0; i < 24; i++)
      run(2'($urandom % 4), rnd_operand(), rnd_operand(), AW'($urandom), int'($urandom % 4));

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
